// File: rtl/reg_file_cfg.sv
// Register file whose low registers double as ALU operands and UART/clock-divider
// configuration; configuration writes are validated and flagged with one-cycle pulses.
module reg_file_cfg #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR      = 4
) (
  input  logic                 REF_CLK,
  input  logic                 SYNC_RST,
  input  logic                 WrEn,
  input  logic                 RdEn,
  input  logic [ADDR-1:0]      Addr,
  input  logic [BUS_WIDTH-1:0] Wr_D,
  output logic [BUS_WIDTH-1:0] Rd_D,
  output logic                 Rd_D_Valid,
  output logic [BUS_WIDTH-1:0] REG0,
  output logic [BUS_WIDTH-1:0] REG1,
  output logic                 UART_PAR_EN,
  output logic                 UART_PAR_TYP,
  output logic [5:0]           UART_PRESCALE,
  output logic [BUS_WIDTH-1:0] DIV_RATIO,
  output logic                 CFG_UPDATE,
  output logic                 WR_ERR
);

  localparam logic [ADDR-1:0]      UART_CFG_ADDR = ADDR'(2);
  localparam logic [ADDR-1:0]      DIV_CFG_ADDR  = ADDR'(3);
  localparam logic [BUS_WIDTH-1:0] UART_CFG_RST  = BUS_WIDTH'(8'h81);
  localparam logic [BUS_WIDTH-1:0] DIV_CFG_RST   = BUS_WIDTH'(8'h20);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic                 wr_reject;
  logic                 wr_accept;
  logic                 cfg_accept;
  logic                 rd_accept;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    wr_reject = 1'b0;
    if (WrEn) begin
      if (Addr == UART_CFG_ADDR)
        wr_reject = !(Wr_D[7:2] == 6'd8 || Wr_D[7:2] == 6'd16 || Wr_D[7:2] == 6'd32);
      else if (Addr == DIV_CFG_ADDR)
        wr_reject = (Wr_D == '0);
    end
  end

  assign wr_accept  = WrEn && !wr_reject;
  assign cfg_accept = wr_accept && (Addr == UART_CFG_ADDR || Addr == DIV_CFG_ADDR);
  assign rd_accept  = RdEn && !WrEn;

  // NOTE: the array sits inside the async reset because the config registers need
  // defined power-up values; non-blocking assignments keep all state updates parallel.
  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 2)      mem[i] <= UART_CFG_RST;
        else if (i == 3) mem[i] <= DIV_CFG_RST;
        else             mem[i] <= '0;
      end
    end else if (wr_accept) begin
      mem[Addr] <= Wr_D;
    end
  end

  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      Rd_D       <= '0;
      Rd_D_Valid <= 1'b0;
      CFG_UPDATE <= 1'b0;
      WR_ERR     <= 1'b0;
    end else begin
      if (rd_accept) Rd_D <= mem[Addr];
      Rd_D_Valid <= rd_accept;
      CFG_UPDATE <= cfg_accept;
      WR_ERR     <= wr_reject;
    end
  end

  assign REG0          = mem[0];
  assign REG1          = mem[1];
  assign UART_PAR_EN   = mem[2][0];
  assign UART_PAR_TYP  = mem[2][1];
  assign UART_PRESCALE = mem[2][7:2];
  assign DIV_RATIO     = mem[3];

endmodule

// File: tb/tb_reg_file_cfg.sv
// Directed self-checking bench for reg_file_cfg: reset values, read/write,
// config validation, strobe collision and asynchronous reset mid-operation.
module tb_reg_file_cfg;

  logic       REF_CLK = 1'b0;
  logic       SYNC_RST;
  logic       WrEn, RdEn;
  logic [3:0] Addr;
  logic [7:0] Wr_D;
  logic [7:0] Rd_D, REG0, REG1, DIV_RATIO;
  logic       Rd_D_Valid, UART_PAR_EN, UART_PAR_TYP, CFG_UPDATE, WR_ERR;
  logic [5:0] UART_PRESCALE;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_cfg #(.BUS_WIDTH(8), .DEPTH(16), .ADDR(4)) dut (
    .REF_CLK(REF_CLK), .SYNC_RST(SYNC_RST), .WrEn(WrEn), .RdEn(RdEn),
    .Addr(Addr), .Wr_D(Wr_D), .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid),
    .REG0(REG0), .REG1(REG1), .UART_PAR_EN(UART_PAR_EN), .UART_PAR_TYP(UART_PAR_TYP),
    .UART_PRESCALE(UART_PRESCALE), .DIV_RATIO(DIV_RATIO),
    .CFG_UPDATE(CFG_UPDATE), .WR_ERR(WR_ERR)
  );

  always #5 REF_CLK = ~REF_CLK;

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge REF_CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
    WrEn = we; RdEn = re; Addr = a; Wr_D = d;
  endtask

  task automatic test_reset();
    SYNC_RST = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    #12;
    n_checks++; if (Rd_D !== 8'h00) begin n_fail++; $display("FAIL rst_rd_d: got %h want 00", Rd_D); end
    n_checks++; if (Rd_D_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", Rd_D_Valid); end
    n_checks++; if (CFG_UPDATE !== 1'b0 || WR_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: cfg %b err %b want 0 0", CFG_UPDATE, WR_ERR); end
    SYNC_RST = 1'b1;
    tick();
    n_checks++; if (UART_PRESCALE !== 6'd32) begin n_fail++; $display("FAIL rst_prescale: got %0d want 32", UART_PRESCALE); end
    n_checks++; if (UART_PAR_EN !== 1'b1 || UART_PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL rst_parity: en %b typ %b want 1 0", UART_PAR_EN, UART_PAR_TYP); end
    n_checks++; if (DIV_RATIO !== 8'h20) begin n_fail++; $display("FAIL rst_div: got %h want 20", DIV_RATIO); end
    n_checks++; if (REG0 !== 8'h00 || REG1 !== 8'h00) begin n_fail++; $display("FAIL rst_regs: reg0 %h reg1 %h want 00 00", REG0, REG1); end
    n_checks++; if (Rd_D_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_rel: got %b want 0", Rd_D_Valid); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 4'd0, 8'h5A);
    tick();
    n_checks++; if (REG0 !== 8'h5A) begin n_fail++; $display("FAIL wr_reg0: got %h want 5a", REG0); end
    n_checks++; if (CFG_UPDATE !== 1'b0 || WR_ERR !== 1'b0) begin n_fail++; $display("FAIL wr0_pulses: cfg %b err %b want 0 0", CFG_UPDATE, WR_ERR); end
    drive(1'b0, 1'b1, 4'd0, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h5A || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL rd0: data %h valid %b want 5a 1", Rd_D, Rd_D_Valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 4'd1, 8'h77);
    tick();
    n_checks++; if (REG1 !== 8'h77) begin n_fail++; $display("FAIL wr_reg1: got %h want 77", REG1); end
    drive(1'b0, 1'b1, 4'd1, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h77 || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd1: data %h valid %b want 77 1", Rd_D, Rd_D_Valid); end
    Addr = 4'd0;
    tick();
    n_checks++; if (Rd_D !== 8'h5A || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd0: data %h valid %b want 5a 1", Rd_D, Rd_D_Valid); end
    drive(1'b0, 1'b0, 4'd1, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h5A || Rd_D_Valid !== 1'b0) begin n_fail++; $display("FAIL rd_hold: data %h valid %b want 5a 0", Rd_D, Rd_D_Valid); end
  endtask

  task automatic test_uart_cfg();
    drive(1'b1, 1'b0, 4'd2, 8'h41);
    tick();
    n_checks++; if (UART_PRESCALE !== 6'd16 || UART_PAR_EN !== 1'b1 || UART_PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL cfg41: pre %0d en %b typ %b want 16 1 0", UART_PRESCALE, UART_PAR_EN, UART_PAR_TYP); end
    n_checks++; if (CFG_UPDATE !== 1'b1 || WR_ERR !== 1'b0) begin n_fail++; $display("FAIL cfg41_pulses: cfg %b err %b want 1 0", CFG_UPDATE, WR_ERR); end
    drive(1'b1, 1'b0, 4'd2, 8'h29);
    tick();
    n_checks++; if (CFG_UPDATE !== 1'b0 || WR_ERR !== 1'b1) begin n_fail++; $display("FAIL cfg29_pulses: cfg %b err %b want 0 1", CFG_UPDATE, WR_ERR); end
    n_checks++; if (UART_PRESCALE !== 6'd16) begin n_fail++; $display("FAIL cfg29_keep: pre %0d want 16", UART_PRESCALE); end
    drive(1'b0, 1'b1, 4'd2, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h41 || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL rd_after_rej: data %h valid %b want 41 1", Rd_D, Rd_D_Valid); end
    n_checks++; if (WR_ERR !== 1'b0 || CFG_UPDATE !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: err %b cfg %b want 0 0", WR_ERR, CFG_UPDATE); end
    drive(1'b1, 1'b0, 4'd2, 8'h22);
    tick();
    n_checks++; if (UART_PRESCALE !== 6'd8 || UART_PAR_EN !== 1'b0 || UART_PAR_TYP !== 1'b1 || CFG_UPDATE !== 1'b1) begin n_fail++; $display("FAIL cfg22: pre %0d en %b typ %b cfg %b want 8 0 1 1", UART_PRESCALE, UART_PAR_EN, UART_PAR_TYP, CFG_UPDATE); end
    drive(1'b0, 1'b1, 4'd2, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h22 || CFG_UPDATE !== 1'b0) begin n_fail++; $display("FAIL rd_after_wr: data %h cfg %b want 22 0", Rd_D, CFG_UPDATE); end
  endtask

  task automatic test_div_ratio();
    drive(1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    n_checks++; if (DIV_RATIO !== 8'h20 || WR_ERR !== 1'b1 || CFG_UPDATE !== 1'b0) begin n_fail++; $display("FAIL div0: div %h err %b cfg %b want 20 1 0", DIV_RATIO, WR_ERR, CFG_UPDATE); end
    drive(1'b1, 1'b0, 4'd3, 8'h05);
    tick();
    n_checks++; if (DIV_RATIO !== 8'h05 || WR_ERR !== 1'b0 || CFG_UPDATE !== 1'b1) begin n_fail++; $display("FAIL div5: div %h err %b cfg %b want 05 0 1", DIV_RATIO, WR_ERR, CFG_UPDATE); end
    drive(1'b1, 1'b0, 4'd15, 8'h99);
    tick();
    n_checks++; if (CFG_UPDATE !== 1'b0 || WR_ERR !== 1'b0) begin n_fail++; $display("FAIL gp15_pulses: cfg %b err %b want 0 0", CFG_UPDATE, WR_ERR); end
    drive(1'b0, 1'b1, 4'd15, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'h99 || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL rd15: data %h valid %b want 99 1", Rd_D, Rd_D_Valid); end
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b1, 4'd5, 8'hC3);
    tick();
    n_checks++; if (Rd_D_Valid !== 1'b0 || Rd_D !== 8'h99) begin n_fail++; $display("FAIL collide: valid %b data %h want 0 99", Rd_D_Valid, Rd_D); end
    drive(1'b0, 1'b1, 4'd5, 8'h00);
    tick();
    n_checks++; if (Rd_D !== 8'hC3 || Rd_D_Valid !== 1'b1) begin n_fail++; $display("FAIL rd5: data %h valid %b want c3 1", Rd_D, Rd_D_Valid); end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 1'b0, 4'd3, 8'h07);
    tick();
    n_checks++; if (DIV_RATIO !== 8'h07 || CFG_UPDATE !== 1'b1) begin n_fail++; $display("FAIL div7: div %h cfg %b want 07 1", DIV_RATIO, CFG_UPDATE); end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    SYNC_RST = 1'b0;
    #1;
    n_checks++; if (CFG_UPDATE !== 1'b0 || DIV_RATIO !== 8'h20) begin n_fail++; $display("FAIL midrst: cfg %b div %h want 0 20", CFG_UPDATE, DIV_RATIO); end
    n_checks++; if (Rd_D !== 8'h00 || REG0 !== 8'h00 || UART_PRESCALE !== 6'd32) begin n_fail++; $display("FAIL midrst_regs: rd %h reg0 %h pre %0d want 00 00 32", Rd_D, REG0, UART_PRESCALE); end
    tick();
    SYNC_RST = 1'b1;
    tick();
    n_checks++; if (CFG_UPDATE !== 1'b0 || WR_ERR !== 1'b0 || Rd_D_Valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_pulses: cfg %b err %b valid %b want 0 0 0", CFG_UPDATE, WR_ERR, Rd_D_Valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_uart_cfg();
    test_div_ratio();
    test_collision();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
